// File: rtl/config_pkg.sv
// Shared definitions for the configuration chain tile.
// Holds the source-select encoding and the bit-counter width helper so the
// tile and anything that drives it agree on both.
package config_pkg;

    // Which serial source feeds the chain.
    typedef enum logic {
        SRC_HARD = 1'b0,
        SRC_SOFT = 1'b1
    } src_sel_e;

    // Width of the frame bit counter. It must hold the longest legal frame
    // (every segment active) plus one spare count, so that the saturated value
    // can never be mistaken for a valid frame length.
    function automatic int cnt_width(input int num_seg, input int seg_w);
        return $clog2(num_seg * (seg_w + 1) + 2);
    endfunction

endpackage

// File: rtl/config_seg.sv
// Purpose: one configurable segment of the chain: shift register, bypass, shadow copy, active flag.
// Latency: ser_out is combinational from the register or from ser_in; the shadow and flag update one cycle after load.
// Backpressure: none; the segment shifts whenever shift_en is high and it is active, and holds otherwise.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   shift_en   - shift one bit this cycle (only if the segment is active)
//   ser_in     - serial data from the previous stage
//   load       - accepted commit: capture the shift register, take the new flag
//   hdr_bit    - header bit that becomes the new active flag on load
//   ser_out    - serial data toward the next stage
//   active     - committed active flag (routes the chain)
//   cfg        - committed segment contents
module config_seg #(
    parameter int SEG_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             load,
    input  logic             hdr_bit,
    output logic             ser_out,
    output logic             active,
    output logic [SEG_W-1:0] cfg
);

    logic [SEG_W-1:0] sreg;

    // Bit 0 is nearest the chain input; bit SEG_W-1 leaves first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            cfg    <= '0;
            active <= 1'b1;
        end else begin
            if (shift_en && active) begin
                sreg <= {sreg[SEG_W-2:0], ser_in};
            end
            if (load) begin
                // The frame was routed by the current flag, so only a segment
                // that was active actually received payload bits.
                if (active) begin
                    cfg <= sreg;
                end
                active <= hdr_bit;
            end
        end
    end

    // Inactive segments are transparent so the frame skips them.
    assign ser_out = active ? sreg[SEG_W-1] : ser_in;

endmodule

// File: rtl/config_chain_tile.sv
// Purpose: daisy-chainable serial configuration tile with segment-enable header and checked commit.
// Latency: cfg_out/seg_active/frame_err update one cycle after commit is sampled; shift_out is combinational from chain state.
// Backpressure: none; a shift or commit is taken every cycle it is presented.
//
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   sel_soft                     - 1 selects the soft shift pair, 0 the hard pair
//   shift_en_soft, shift_in_soft - soft source enable and data
//   shift_en_hard, shift_in_hard - hard source enable and data
//   commit                       - transfer the chain into the shadow outputs
//   cfg_out                      - committed config, segment k at [k*SEG_W +: SEG_W]
//   seg_active                   - committed segment-enable header
//   shift_out                    - serial output toward the next tile
//   frame_err                    - sticky: last commit was rejected
module config_chain_tile
    import config_pkg::*;
#(
    parameter int NUM_SEG = 2,
    parameter int SEG_W   = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_soft,
    input  logic                     shift_en_soft,
    input  logic                     shift_en_hard,
    input  logic                     shift_in_soft,
    input  logic                     shift_in_hard,
    input  logic                     commit,
    output logic [NUM_SEG*SEG_W-1:0] cfg_out,
    output logic [NUM_SEG-1:0]       seg_active,
    output logic                     shift_out,
    output logic                     frame_err
);

    localparam int CW = cnt_width(NUM_SEG, SEG_W);

    src_sel_e          src;
    logic              shift_en;
    logic              shift_in;
    logic [NUM_SEG-1:0] hdr;
    logic [NUM_SEG-1:0] hdr_nxt;
    logic [NUM_SEG:0]   link;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      frame_len;
    logic               commit_ok;

    assign src      = src_sel_e'(sel_soft);
    assign shift_en = (src == SRC_SOFT) ? shift_en_soft : shift_en_hard;
    assign shift_in = (src == SRC_SOFT) ? shift_in_soft : shift_in_hard;

    // Header is always in the chain, directly behind the input.
    always_comb begin
        hdr_nxt    = hdr << 1;
        hdr_nxt[0] = shift_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr <= '0;
        end else if (shift_en) begin
            hdr <= hdr_nxt;
        end
    end

    // Expected frame length from the committed header.
    always_comb begin
        frame_len = CW'(NUM_SEG);
        for (int k = 0; k < NUM_SEG; k++) begin
            if (seg_active[k]) begin
                frame_len = frame_len + CW'(SEG_W);
            end
        end
    end

    // Compared against the pre-shift count, so a shift in the commit cycle
    // belongs to the next frame.
    assign commit_ok = commit && (cnt == frame_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (commit) begin
            cnt <= shift_en ? CW'(1) : '0;
        end else if (shift_en && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (commit) begin
            frame_err <= !commit_ok;
        end
    end

    // link[k] feeds segment k; link[NUM_SEG] is whatever the last active
    // stage presents (header MSB when every segment is bypassed).
    assign link[0] = hdr[NUM_SEG-1];

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
        config_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .ser_in   (link[k]),
            .load     (commit_ok),
            .hdr_bit  (hdr[k]),
            .ser_out  (link[k+1]),
            .active   (seg_active[k]),
            .cfg      (cfg_out[k*SEG_W +: SEG_W])
        );
    end

    assign shift_out = link[NUM_SEG];

endmodule

// File: tb/tb_config_chain_tile.sv
module tb_config_chain_tile;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int NB = N + N * W;

    typedef bit bitq_t[$];
    typedef int intq_t[$];
    typedef struct {
        logic [N*W-1:0] cfg;
        logic [N-1:0]   act;
        bit             err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           sel_soft;
    logic           shift_en_soft;
    logic           shift_en_hard;
    logic           shift_in_soft;
    logic           shift_in_hard;
    logic           commit;
    logic [N*W-1:0] cfg_out;
    logic [N-1:0]   seg_active;
    logic           shift_out;
    logic           frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t exp_q[$];
    bit   so_q[$];

    // Reference model state: committed outputs, bits shifted since the last
    // commit, and the contents of every chain location.
    logic [N*W-1:0] m_cfg;
    logic [N-1:0]   m_act;
    bit             m_err;
    bit             m_hist[$];
    bit             m_img[NB];

    config_chain_tile #(
        .NUM_SEG (N),
        .SEG_W   (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel_soft      (sel_soft),
        .shift_en_soft (shift_en_soft),
        .shift_en_hard (shift_en_hard),
        .shift_in_soft (shift_in_soft),
        .shift_in_hard (shift_in_hard),
        .commit        (commit),
        .cfg_out       (cfg_out),
        .seg_active    (seg_active),
        .shift_out     (shift_out),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // Chain locations in the order a bit travels: header, then each active
    // segment. Location N+k*W+j is segment k bit j.
    function automatic intq_t positions(input logic [N-1:0] act);
        intq_t q;
        for (int i = 0; i < N; i++) q.push_back(i);
        for (int k = 0; k < N; k++)
            if (act[k])
                for (int j = 0; j < W; j++) q.push_back(N + k * W + j);
        return q;
    endfunction

    // Bits to shift, in order, so that the active chain ends up holding
    // hdr and data (data[k*W+j] = segment k bit j).
    function automatic bitq_t frame_bits(input logic [N-1:0] hdr, input logic [N*W-1:0] data,
                                         input logic [N-1:0] act);
        intq_t p;
        bitq_t q;
        p = positions(act);
        for (int i = p.size() - 1; i >= 0; i--)
            q.push_back((p[i] < N) ? bit'(hdr[p[i]]) : bit'(data[p[i] - N]));
        return q;
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit din, input bit cm);
        intq_t          p;
        logic [N-1:0]   nxt_act;
        exp_t           e;
        int             len;
        if (r) begin
            m_cfg = '0;
            m_act = '1;
            m_err = 1'b0;
            m_hist.delete();
            foreach (m_img[i]) m_img[i] = 1'b0;
            e.cfg = m_cfg; e.act = m_act; e.err = m_err;
            exp_q.push_back(e);
        end else begin
            nxt_act = m_act;
            p = positions(m_act);
            len = p.size();
            if (cm) begin
                if (m_hist.size() == len) begin
                    // The most recent bit sits at chain index 0.
                    for (int i = 0; i < N; i++) nxt_act[i] = m_hist[len - 1 - i];
                    for (int idx = N; idx < len; idx++) m_cfg[p[idx] - N] = m_hist[len - 1 - idx];
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_hist.delete();
            end
            if (en) begin
                for (int i = len - 1; i > 0; i--) m_img[p[i]] = m_img[p[i-1]];
                m_img[p[0]] = din;
                m_hist.push_back(din);
            end
            m_act = nxt_act;
            if (cm) begin
                e.cfg = m_cfg; e.act = m_act; e.err = m_err;
                exp_q.push_back(e);
            end
        end
        p = positions(m_act);
        so_q.push_back(m_img[p[p.size() - 1]]);
    endtask

    // One clock: drive inputs (noise on the unselected source), predict, advance.
    task automatic step(input bit r, input bit sel, input bit en, input bit din, input bit cm);
        rst      = r;
        sel_soft = sel;
        commit   = cm;
        if (sel) begin
            shift_en_soft = en;
            shift_in_soft = din;
            shift_en_hard = 1'($urandom_range(0, 1));
            shift_in_hard = 1'($urandom_range(0, 1));
        end else begin
            shift_en_hard = en;
            shift_in_hard = din;
            shift_en_soft = 1'($urandom_range(0, 1));
            shift_in_soft = 1'($urandom_range(0, 1));
        end
        model_edge(r, en, din, cm);
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input bitq_t q, input bit sel, input int start);
        for (int t = start; t < q.size(); t++) step(1'b0, sel, 1'b1, q[t], 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: pops the expectations queued for each clock edge and compares
    // them against the DUT on the following falling edge.
    initial begin
        int   so_due;
        int   ex_due;
        exp_t e;
        bit   eb;
        forever begin
            @(posedge clk);
            so_due = so_q.size();
            ex_due = exp_q.size();
            @(negedge clk);
            cyc++;
            repeat (so_due) begin
                eb = so_q.pop_front();
                chk("shift_out", 32'(shift_out), 32'(eb));
            end
            repeat (ex_due) begin
                e = exp_q.pop_front();
                chk("cfg_out", 32'(cfg_out), 32'(e.cfg));
                chk("seg_active", 32'(seg_active), 32'(e.act));
                chk("frame_err", 32'(frame_err), 32'(e.err));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bitq_t        q;
        bitq_t        q2;
        bitq_t        cur;
        logic [N-1:0] hdr;
        logic [N-1:0] next_act;
        bit           carry;
        bit           sel;
        bit           acc;
        int           start;
        int           mode;

        // Reset state.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full 10-bit frame via soft source: seg1=A, seg0=5, hdr=11.
        q = frame_bits(2'b11, 8'hA5, m_act);
        shift_bits(q, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Short frame (9 bits): rejected, cfg kept.
        q = frame_bits(2'b11, 8'h3C, m_act);
        shift_bits(q, 1'b1, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Commit hdr=01, then a 6-bit frame through the hard source with seg0=3.
        q = frame_bits(2'b01, 8'hA5, m_act);
        shift_bits(q, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        q = frame_bits(2'b01, 8'h53, m_act);
        shift_bits(q, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Commit together with a shift: next frame needs one bit fewer.
        q = frame_bits(2'b11, 8'h96, m_act);
        shift_bits(q, 1'b1, 0);
        q2 = frame_bits(2'b11, 8'h4E, 2'b11);
        step(1'b0, 1'b1, 1'b1, q2[0], 1'b1);
        shift_bits(q2, 1'b1, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset after 4 of 10 bits (with shift and commit also asserted), then a clean frame.
        q = frame_bits(2'b11, 8'h7C, m_act);
        for (int t = 0; t < 4; t++) step(1'b0, 1'b1, 1'b1, q[t], 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        q = frame_bits(2'b11, 8'hD2, m_act);
        shift_bits(q, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized frames: random headers, sources, idle gaps, short/long
        // frames and commits that carry the first bit of the next frame.
        carry = 1'b0;
        hdr = N'($urandom_range(0, 3));
        cur = frame_bits(hdr, 8'($urandom), m_act);
        for (int f = 0; f < 40; f++) begin
            sel   = 1'($urandom_range(0, 1));
            start = carry ? 1 : 0;
            if (!carry) begin
                mode = $urandom_range(0, 5);
                if (mode == 0) start = 1;
                else if (mode == 1) cur.push_front(1'($urandom_range(0, 1)));
            end
            for (int t = start; t < cur.size(); t++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, sel, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                step(1'b0, sel, 1'b1, cur[t], 1'b0);
            end
            acc      = (m_hist.size() == N + W * $countones(m_act));
            next_act = acc ? hdr : m_act;
            hdr      = N'($urandom_range(0, 3));
            cur      = frame_bits(hdr, 8'($urandom), next_act);
            carry    = ($urandom_range(0, 3) == 0);
            step(1'b0, sel, carry, cur[0], 1'b1);
        end

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (so_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d pending expected=0/0", so_q.size(), exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
